// File: rtl/fast_square_sweep_ctrl_pkg.sv
// Shared types and constants for the fast-square sweep sequencer.
// State encodings, default addresses, control bits and config bundle.
package fast_square_sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_SETTLE = 3'd2,
    S_RECORD = 3'd3,
    S_STEP   = 3'd4,
    S_DRAIN  = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  localparam logic [6:0] CTRL_ADDR_DEF   = 7'd3;
  localparam logic [6:0] STEPS_ADDR_DEF  = 7'd4;
  localparam logic [6:0] TIMING_ADDR_DEF = 7'd5;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;
  localparam int CTRL_CONT_BIT  = 2;

  localparam int DRAIN_WORDS_DEF = 9;
  localparam int ARM_CYCLES      = 2;

  // Working copy of the sweep settings, frozen on entry to ARM.
  typedef struct packed {
    logic [7:0]  num_steps;
    logic [15:0] settle;
    logic [15:0] timeout;
    logic        cont;
  } sweep_cfg_t;

  // A zero settle time still spends one cycle in SETTLE.
  function automatic logic [15:0] settle_load(
    input logic [15:0] t
  );
    return (t == 16'd0) ? 16'd0 : t - 16'd1;
  endfunction

  function automatic sweep_cfg_t cfg_load(
    input logic [7:0]  steps,
    input logic [31:0] timing,
    input logic        cont
  );
    sweep_cfg_t c;
    c.num_steps = steps;
    c.settle    = timing[15:0];
    c.timeout   = timing[31:16];
    c.cont      = cont;
    return c;
  endfunction

endpackage

// File: rtl/fast_square_sweep_ctrl_setting_reg.sv
// Settings-bus register: captures data when its address is written.
// Holds the value until the next matching write or reset.
module fast_square_sweep_ctrl_setting_reg #(
  parameter logic [6:0]       MY_ADDR  = 7'd0,
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] AT_RESET = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             strobe,
  input  logic [6:0]       addr,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] val_d;

  // Next value: take bus data on an address match.
  always_comb begin
    val_d = val_q;
    if (strobe && (addr == MY_ADDR)) begin
      val_d = data;
    end
  end

  // Storage with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      val_q <= AT_RESET;
    end else begin
      val_q <= val_d;
    end
  end

  assign out = val_q;

endmodule

// File: rtl/fast_square_sweep_ctrl.sv
// Sweep sequencer for the fast-square RX datapath.
// Drives rx_reset, record and freq_step through a stepped sweep.
module fast_square_sweep_ctrl
  import fast_square_sweep_ctrl_pkg::*;
#(
  parameter logic [6:0] CTRLADDR          = CTRL_ADDR_DEF,
  parameter logic [6:0] STEPSADDR         = STEPS_ADDR_DEF,
  parameter logic [6:0] TIMINGADDR        = TIMING_ADDR_DEF,
  parameter int         RECORD_TICKS_LOG2 = 14,
  parameter int         DRAIN_WORDS       = DRAIN_WORDS_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        serial_strobe,
  input  logic        data_out_strobe,
  output logic        rx_reset,
  output logic        record,
  output logic        freq_step,
  output logic        busy,
  output logic        sweep_done,
  output logic [7:0]  step_index,
  output logic        drain_overrun
);

  localparam int CW  =
    (RECORD_TICKS_LOG2 > 16) ? RECORD_TICKS_LOG2 : 16;
  localparam int SCW = $clog2(DRAIN_WORDS + 1);

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] ARM_LOAD = CW'(ARM_CYCLES - 1);
  localparam logic [CW-1:0] REC_LOAD =
    CW'((64'd1 << RECORD_TICKS_LOG2) - 64'd1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(DRAIN_WORDS - 1);

  logic [7:0]  steps_reg;
  logic [31:0] timing_reg;

  logic ctrl_wr;
  logic start_p;
  logic abort_p;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic [7:0]     step_q, step_d;
  logic           ovr_q, ovr_d;
  sweep_cfg_t     cfg_q, cfg_d;

  logic rx_q, rx_d;
  logic rec_q, rec_d;
  logic fs_q, fs_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic [8:0]    nsteps9;
  logic          last_step;
  logic          words_done;
  logic          timed_out;
  logic [CW-1:0] settle_ld;

  fast_square_sweep_ctrl_setting_reg #(
    .MY_ADDR (STEPSADDR),
    .WIDTH   (8),
    .AT_RESET(8'd0)
  ) u_steps (
    .clock  (clock),
    .reset_n(reset_n),
    .strobe (serial_strobe),
    .addr   (serial_addr),
    .data   (serial_data[7:0]),
    .out    (steps_reg)
  );

  fast_square_sweep_ctrl_setting_reg #(
    .MY_ADDR (TIMINGADDR),
    .WIDTH   (32),
    .AT_RESET(32'd0)
  ) u_timing (
    .clock  (clock),
    .reset_n(reset_n),
    .strobe (serial_strobe),
    .addr   (serial_addr),
    .data   (serial_data),
    .out    (timing_reg)
  );

  // Abort dominates a start carried by the same write.
  assign ctrl_wr = serial_strobe &&
                   (serial_addr == CTRLADDR);
  assign abort_p = ctrl_wr &&
                   serial_data[CTRL_ABORT_BIT];
  assign start_p = ctrl_wr &&
                   serial_data[CTRL_START_BIT] &&
                   !serial_data[CTRL_ABORT_BIT];

  // A programmed count of zero means a full 256-step sweep.
  assign nsteps9 = (cfg_q.num_steps == 8'd0) ?
                   9'd256 : {1'b0, cfg_q.num_steps};
  assign last_step  = ({1'b0, step_q} + 9'd1) >= nsteps9;
  assign words_done = data_out_strobe && (sc_q == SC_LAST);
  assign timed_out  = (cfg_q.timeout != 16'd0) &&
                      (cnt_q == '0);
  assign settle_ld  = CW'(settle_load(cfg_q.settle));

  // Next state, shared counter reloads and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sc_d    = sc_q;
    step_d  = step_q;
    ovr_d   = ovr_q;
    cfg_d   = cfg_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_p) begin
          state_d = S_ARM;
          cnt_d   = ARM_LOAD;
          step_d  = '0;
          ovr_d   = 1'b0;
          cfg_d   = cfg_load(steps_reg, timing_reg,
                      serial_data[CTRL_CONT_BIT]);
        end
      end
      S_ARM: begin
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
          cnt_d   = settle_ld;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_RECORD;
          cnt_d   = REC_LOAD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_RECORD: begin
        if (cnt_q == '0) begin
          state_d = S_STEP;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_STEP: begin
        state_d = S_DRAIN;
        sc_d    = '0;
        cnt_d   = CW'(cfg_q.timeout - 16'd1);
      end
      S_DRAIN: begin
        if (data_out_strobe) begin
          sc_d = sc_q + SCW'(1);
        end
        if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end
        if (words_done || timed_out) begin
          if (!words_done) begin
            ovr_d = 1'b1;
          end
          if (!last_step) begin
            state_d = S_SETTLE;
            step_d  = step_q + 8'd1;
            cnt_d   = settle_ld;
          end else if (cfg_q.cont) begin
            state_d = S_ARM;
            step_d  = '0;
            cnt_d   = ARM_LOAD;
            cfg_d   = cfg_load(steps_reg, timing_reg,
                        cfg_q.cont);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_p) begin
      state_d = S_IDLE;
      step_d  = step_q;
      ovr_d   = ovr_q;
    end

    rx_d   = (state_d == S_ARM);
    rec_d  = (state_d == S_RECORD);
    fs_d   = (state_d == S_STEP);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, counters and output registers; rx_reset held high in reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sc_q    <= '0;
      step_q  <= '0;
      ovr_q   <= 1'b0;
      cfg_q   <= '0;
      rx_q    <= 1'b1;
      rec_q   <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sc_q    <= sc_d;
      step_q  <= step_d;
      ovr_q   <= ovr_d;
      cfg_q   <= cfg_d;
      rx_q    <= rx_d;
      rec_q   <= rec_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rx_reset      = rx_q;
  assign record        = rec_q;
  assign freq_step     = fs_q;
  assign busy          = busy_q;
  assign sweep_done    = done_q;
  assign step_index    = step_q;
  assign drain_overrun = ovr_q;

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Scoreboard bench for the fast-square sweep sequencer.
// Expected pulse events are queued by stimulus, checked by a monitor.
module tb_fast_square_sweep_ctrl;

  localparam logic [6:0] A_CTRL   = 7'd3;
  localparam logic [6:0] A_STEPS  = 7'd4;
  localparam logic [6:0] A_TIMING = 7'd5;

  localparam int K_RX   = 0;
  localparam int K_REC  = 1;
  localparam int K_FS   = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int kind;
    int len;
    int idx;
  } ev_t;

  logic        clock;
  logic        reset_n;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;
  logic        data_out_strobe;
  logic        rx_reset;
  logic        record;
  logic        freq_step;
  logic        busy;
  logic        sweep_done;
  logic [7:0]  step_index;
  logic        drain_overrun;

  int   checks   = 0;
  int   failures = 0;
  int   n_str    = 9;
  ev_t  sb[$];

  int   rx_run  = 0;
  int   rec_run = 0;
  int   fs_run  = 0;
  int   dn_run  = 0;
  logic rec_prev = 1'b0;
  logic fs_prev  = 1'b0;

  fast_square_sweep_ctrl #(
    .RECORD_TICKS_LOG2(4)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .serial_addr    (serial_addr),
    .serial_data    (serial_data),
    .serial_strobe  (serial_strobe),
    .data_out_strobe(data_out_strobe),
    .rx_reset       (rx_reset),
    .record         (record),
    .freq_step      (freq_step),
    .busy           (busy),
    .sweep_done     (sweep_done),
    .step_index     (step_index),
    .drain_overrun  (drain_overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d",
               nm, act, exp);
    end
  endtask

  function automatic void push(input int k, input int l,
                               input int i);
    ev_t e;
    e.kind = k;
    e.len  = l;
    e.idx  = i;
    sb.push_back(e);
  endfunction

  task automatic got(input int k, input int l);
    ev_t e;
    int  i;
    i = int'(step_index);
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL ev_unexpected actual=k%0d/len%0d/idx%0d expected=none",
               k, l, i);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.len != l || e.idx != i) begin
        failures++;
        $display("FAIL ev actual=k%0d/len%0d/idx%0d expected=k%0d/len%0d/idx%0d",
                 k, l, i, e.kind, e.len, e.idx);
      end
    end
  endtask

  // Monitor: turns output pulses into events and scores them.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!reset_n) begin
        rx_run   = 0;
        rec_run  = 0;
        fs_run   = 0;
        dn_run   = 0;
        rec_prev = 1'b0;
        fs_prev  = 1'b0;
      end else begin
        if (freq_step && !fs_prev)
          chk("fs_after_rec", int'(rec_prev), 1);
        if (rx_reset) rx_run++;
        else if (rx_run > 0) begin
          got(K_RX, rx_run);
          rx_run = 0;
        end
        if (record) rec_run++;
        else if (rec_run > 0) begin
          got(K_REC, rec_run);
          rec_run = 0;
        end
        if (freq_step) fs_run++;
        else if (fs_run > 0) begin
          got(K_FS, fs_run);
          fs_run = 0;
        end
        if (sweep_done) dn_run++;
        else if (dn_run > 0) begin
          got(K_DONE, dn_run);
          dn_run = 0;
        end
        rec_prev = record;
        fs_prev  = freq_step;
      end
    end
  end

  // Datapath stand-in: strobes starting in STEP, n_str of them in DRAIN.
  initial begin
    data_out_strobe = 1'b0;
    forever begin
      @(negedge clock);
      if (freq_step) begin
        data_out_strobe = 1'b1;
        repeat (n_str + 1) @(negedge clock);
        data_out_strobe = 1'b0;
      end
    end
  end

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    @(negedge clock);
    serial_addr   = a;
    serial_data   = d;
    serial_strobe = 1'b1;
    @(negedge clock);
    serial_strobe = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("idle", int'(busy), 0);
  endtask

  task automatic wait_rec(input int idx, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!(record && int'(step_index) == idx) &&
               n < budget);
    chk("rec_seen", int'(record && int'(step_index) == idx), 1);
  endtask

  task automatic count_rises(input int want, input int budget);
    int   n;
    int   r;
    logic pr;
    n  = 0;
    r  = 0;
    pr = record;
    while (r < want && n < budget) begin
      @(posedge clock);
      #1;
      n++;
      if (record && !pr) r++;
      pr = record;
    end
    chk("rec_rises", r, want);
  endtask

  task automatic wait_fs(input int budget);
    int n;
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!freq_step && n < budget);
    chk("fs_seen", int'(freq_step), 1);
  endtask

  initial begin
    reset_n       = 1'b0;
    serial_addr   = '0;
    serial_data   = '0;
    serial_strobe = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_rx", int'(rx_reset), 1);
    chk("rst_rec", int'(record), 0);
    chk("rst_fs", int'(freq_step), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(sweep_done), 0);
    chk("rst_idx", int'(step_index), 0);
    chk("rst_ovr", int'(drain_overrun), 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rel_rx", int'(rx_reset), 0);
    chk("rel_busy", int'(busy), 0);

    // Two-step single sweep
    wr(A_STEPS, 32'd2);
    wr(A_TIMING, {16'd0, 16'd3});
    push(K_RX, 2, 0);
    push(K_REC, 16, 0);
    push(K_FS, 1, 0);
    push(K_REC, 16, 1);
    push(K_FS, 1, 1);
    push(K_DONE, 1, 1);
    wr(A_CTRL, 32'd1);
    chk("t1_busy", int'(busy), 1);
    chk("t1_rx", int'(rx_reset), 1);
    @(negedge clock);
    chk("t2_rx", int'(rx_reset), 1);
    @(negedge clock);
    chk("t3_rx", int'(rx_reset), 0);
    chk("t3_busy", int'(busy), 1);
    chk("t3_rec", int'(record), 0);
    repeat (2) @(negedge clock);
    chk("t5_rec", int'(record), 0);
    @(negedge clock);
    chk("t6_rec", int'(record), 1);
    wait_idle(300);
    repeat (3) @(negedge clock);
    chk("sb_t1", sb.size(), 0);

    // Drain timeout with 8 strobes
    n_str = 8;
    wr(A_TIMING, {16'd20, 16'd3});
    push(K_RX, 2, 0);
    push(K_REC, 16, 0);
    push(K_FS, 1, 0);
    push(K_REC, 16, 1);
    push(K_FS, 1, 1);
    push(K_DONE, 1, 1);
    wr(A_CTRL, 32'd1);
    wait_fs(100);
    repeat (20) begin
      @(posedge clock);
      #1;
    end
    chk("ovr_before", int'(drain_overrun), 0);
    @(posedge clock);
    #1;
    chk("ovr_set", int'(drain_overrun), 1);
    wait_idle(300);
    chk("ovr_sticky", int'(drain_overrun), 1);
    repeat (3) @(negedge clock);
    chk("sb_t2", sb.size(), 0);

    // Abort mid-RECORD of the second step
    n_str = 9;
    wr(A_TIMING, {16'd0, 16'd3});
    push(K_RX, 2, 0);
    push(K_REC, 16, 0);
    push(K_FS, 1, 0);
    push(K_REC, 5, 1);
    wr(A_CTRL, 32'd1);
    chk("ovr_clr", int'(drain_overrun), 0);
    wait_rec(1, 200);
    repeat (4) @(posedge clock);
    wr(A_CTRL, 32'd2);
    chk("ab_busy", int'(busy), 0);
    chk("ab_rec", int'(record), 0);
    chk("ab_fs", int'(freq_step), 0);
    chk("ab_idx", int'(step_index), 1);
    repeat (20) @(negedge clock);
    chk("sb_t3", sb.size(), 0);

    // Start while busy is ignored; start+abort stays idle
    wr(A_STEPS, 32'd1);
    push(K_RX, 2, 0);
    push(K_REC, 16, 0);
    push(K_FS, 1, 0);
    push(K_DONE, 1, 0);
    wr(A_CTRL, 32'd1);
    wait_rec(0, 100);
    wr(A_CTRL, 32'd1);
    wait_idle(200);
    repeat (3) @(negedge clock);
    chk("sb_t4", sb.size(), 0);
    wr(A_CTRL, 32'd3);
    chk("sa_busy", int'(busy), 0);
    chk("sa_rx", int'(rx_reset), 0);
    repeat (10) @(negedge clock);
    chk("sa_busy2", int'(busy), 0);
    chk("sb_t4b", sb.size(), 0);

    // Continuous single-step loop until abort
    for (int i = 0; i < 3; i++) begin
      push(K_RX, 2, 0);
      push(K_REC, 16, 0);
      push(K_FS, 1, 0);
    end
    push(K_RX, 2, 0);
    push(K_REC, 1, 0);
    wr(A_CTRL, 32'd5);
    count_rises(4, 600);
    wr(A_CTRL, 32'd2);
    chk("co_busy", int'(busy), 0);
    chk("co_idx", int'(step_index), 0);
    repeat (10) @(negedge clock);
    chk("sb_t5", sb.size(), 0);

    // Reset mid-RECORD, then a 256-step sweep from reset settings
    push(K_RX, 2, 0);
    wr(A_CTRL, 32'd1);
    wait_rec(0, 100);
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("mr_rx", int'(rx_reset), 1);
    chk("mr_rec", int'(record), 0);
    chk("mr_busy", int'(busy), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("mr_rel_rx", int'(rx_reset), 0);
    chk("mr_rel_busy", int'(busy), 0);
    chk("mr_rel_idx", int'(step_index), 0);
    chk("sb_t6", sb.size(), 0);

    push(K_RX, 2, 0);
    for (int i = 0; i < 256; i++) begin
      push(K_REC, 16, i);
      push(K_FS, 1, i);
    end
    push(K_DONE, 1, 255);
    wr(A_CTRL, 32'd1);
    wait_idle(12000);
    chk("s256_idx", int'(step_index), 255);
    chk("s256_ovr", int'(drain_overrun), 0);
    repeat (5) @(negedge clock);
    chk("sb_t7", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/fast_square_sweep_ctrl.md
# fast_square_sweep_ctrl

Sequencer that drives the `record` and `freq_step` inputs of the fast-square receive datapath through a programmed multi-step frequency sweep. It is configured over the serial settings bus and pulses the datapath's reset so the datapath re-latches its carrier and subcarrier settings. For each step it waits for the settling time and gates a fixed-length record window. It then strobes `freq_step` and waits until the datapath's 9-word result dispatch has drained before starting the next step. It sits beside the receive datapath in the RX chain and is the datapath's only source of `record` and `freq_step`.

## Interface
Parameters:
- CTRLADDR, 3, serial address of the control register: bit0 start, bit1 abort, bit2 continuous.
- STEPSADDR, 4, serial address of num_steps[7:0].
- TIMINGADDR, 5, serial address of settle_ticks[15:0] and drain_timeout[31:16].
- RECORD_TICKS_LOG2, 14, log2 of the record window length in clocks.
- DRAIN_WORDS, 9, data_out_strobe count per step (NUM_SUBCARRIERS*2+1).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- serial_addr  in  7  settings bus address.
- serial_data  in  32  settings bus data.
- serial_strobe  in  1  settings bus write strobe.
- data_out_strobe  in  1  the same strobe that feeds the datapath's output dispatch.
- rx_reset  out  1  active-high reset to the datapath.
- record  out  1  record gate to the datapath.
- freq_step  out  1  one-cycle step strobe to the datapath.
- busy  out  1  high whenever the state is not IDLE.
- sweep_done  out  1  one-cycle pulse at the end of the sweep.
- step_index  out  8  index of the current step.
- drain_overrun  out  1  sticky flag; set on drain timeout, cleared by start.

## Operation
- A start pulse is a CTRLADDR write with bit0=1. An abort is a CTRLADDR write with bit1=1.
  - The continuous bit (bit2) is latched on start.
  - Start is ignored while busy.
  - If the same write sets both start and abort, abort wins.
- num_steps=0 means 256 steps.
- States and transitions:
  - IDLE: all strobes low. Start moves to ARM, clears step_index and drain_overrun.
  - ARM: rx_reset=1 for exactly 2 cycles, then SETTLE.
  - SETTLE: record=0 for max(settle_ticks,1) cycles, then RECORD.
  - RECORD: record=1 for exactly 2^RECORD_TICKS_LOG2 cycles, then STEP.
  - STEP: freq_step=1 and record=0 for 1 cycle, then DRAIN.
  - DRAIN: counts data_out_strobe.
    - When the count reaches DRAIN_WORDS, leave DRAIN. If drain_timeout is nonzero and that many cycles elapse first, set drain_overrun and leave DRAIN.
    - Exit goes to SETTLE with step_index+1 if steps remain.
    - Otherwise: in continuous mode, go to ARM with step_index=0. In single mode, go to DONE.
  - DONE: sweep_done=1 for 1 cycle, then IDLE.
- Strobes seen during STEP are not counted, because the datapath's new_data is not yet valid in that cycle.
- Abort in any state sends the block to IDLE on the next cycle.
  - record, freq_step and rx_reset drop; no sweep_done pulse.
  - step_index holds its value.
- Settings writes take effect at the next ARM, except abort, which takes effect immediately.
  - Values are sampled into working registers on entry to ARM.

## Timing
- Reset values: rx_reset=1 while reset_n is low, and 0 on the first cycle after release. All other outputs 0. State is IDLE.
- All outputs are registered.
- Start write at cycle t: busy=1 and rx_reset=1 at t+1 and t+2. SETTLE starts at t+3.
- The record high time is exactly 2^RECORD_TICKS_LOG2 cycles. freq_step rises in the cycle after record falls.
- When the DRAIN_WORDS-th strobe arrives at cycle d, the next SETTLE (or DONE) starts at d+1.
- freq_step is never asserted twice without DRAIN completing or timing out in between.
- Counters are wide enough for 2^RECORD_TICKS_LOG2 and for 16-bit settle/timeout values without wrap.
- step_index is compared as 9-bit so that 256 steps work.

## Structure
- Shared include (alongside config.vh): state encodings, the three default addresses, the control bit positions and DRAIN_WORDS.
- Reuse the existing setting_reg sub-module for the STEPSADDR and TIMINGADDR registers.
- Decode the CTRLADDR write strobe inline to produce the start/abort pulses.
- One FSM plus one shared down-counter, reloaded per state.

## Test plan
- RECORD_TICKS_LOG2=4, num_steps=2, settle=3, 9 strobes per DRAIN -> rx_reset 2 cycles, record high 16 cycles twice, 2 freq_step pulses, sweep_done 1 cycle, busy then 0.
- DRAIN with only 8 strobes and drain_timeout=20 -> drain_overrun=1 after 20 cycles, the sweep continues, and the flag is cleared by the next start.
- Abort written mid-RECORD -> record=0 and busy=0 next cycle, no freq_step, no sweep_done.
- Start written while busy, and start+abort in the same write -> the first is ignored; the second leaves the block in IDLE.
- Continuous mode with num_steps=1 -> the ARM/SETTLE/RECORD/STEP/DRAIN cycle repeats, step_index stays 0, and no sweep_done until abort.
- reset_n low mid-RECORD -> rx_reset=1 and record=0 on the next clock; IDLE after release; num_steps=0 run gives 256 freq_step pulses.
